// File: rtl/full_subtractor.sv
// 1-bit full subtractor: combinational cell, one-cycle registered copy, and an
// LSB-first bit-serial engine that chains the cell over SERIAL_WIDTH valid cycles.
module full_subtractor #(
  parameter int SERIAL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a,
  input  logic                    b,
  input  logic                    bin,
  output logic                    dif,
  output logic                    bor,
  input  logic                    in_valid,
  input  logic                    serial_en,
  input  logic                    serial_start,
  output logic                    dif_q,
  output logic                    bor_q,
  output logic                    out_valid,
  output logic [SERIAL_WIDTH-1:0] serial_result,
  output logic                    serial_borrow,
  output logic                    serial_done
);

  localparam int CNT_W = (SERIAL_WIDTH > 2) ? $clog2(SERIAL_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERIAL_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic                    reg_dif_q, reg_dif_d;
  logic                    reg_bor_q, reg_bor_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    brw_q, brw_d;
  logic [SERIAL_WIDTH-1:0] sr_q, sr_d;
  logic [SERIAL_WIDTH-1:0] result_q, result_d;
  logic                    sborrow_q, sborrow_d;
  logic                    done_q, done_d;

  logic                    step;
  logic                    cin;
  logic                    s_dif;
  logic                    s_bor;
  logic                    last_bit;
  logic [SERIAL_WIDTH-1:0] sr_shift;

  always_comb begin
    dif = a ^ b ^ bin;
    bor = (~a & b) | (~(a ^ b) & bin);
  end

  // The serial bit reuses the cell equations with the chained borrow as carry-in.
  always_comb begin
    step     = in_valid & serial_en;
    cin      = serial_start ? bin : brw_q;
    s_dif    = a ^ b ^ cin;
    s_bor    = (~a & b) | (~(a ^ b) & cin);
    sr_shift = {s_dif, sr_q[SERIAL_WIDTH-1:1]};
    last_bit = step & ~serial_start & (cnt_q == CNT_LAST);
  end

  always_comb begin
    reg_dif_d   = reg_dif_q;
    reg_bor_d   = reg_bor_q;
    out_valid_d = in_valid;
    cnt_d       = cnt_q;
    brw_d       = brw_q;
    sr_d        = sr_q;
    result_d    = result_q;
    sborrow_d   = sborrow_q;
    done_d      = last_bit;
    if (in_valid) begin
      reg_dif_d = dif;
      reg_bor_d = bor;
    end
    if (step) begin
      sr_d  = sr_shift;
      brw_d = s_bor;
      if (serial_start) begin
        cnt_d = CNT_ONE;
      end else if (last_bit) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (last_bit) begin
      result_d  = sr_shift;
      sborrow_d = s_bor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_dif_q   <= 1'b0;
      reg_bor_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      brw_q       <= 1'b0;
      sr_q        <= '0;
      result_q    <= '0;
      sborrow_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      reg_dif_q   <= reg_dif_d;
      reg_bor_q   <= reg_bor_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      brw_q       <= brw_d;
      sr_q        <= sr_d;
      result_q    <= result_d;
      sborrow_q   <= sborrow_d;
      done_q      <= done_d;
    end
  end

  assign dif_q         = reg_dif_q;
  assign bor_q         = reg_bor_q;
  assign out_valid     = out_valid_q;
  assign serial_result = result_q;
  assign serial_borrow = sborrow_q;
  assign serial_done   = done_q;

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench: directed and random stimulus checked against an
// arithmetic reference (a - b - bin, signed) for the cell and whole serial operands.
module tb_full_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a = 1'b0, b = 1'b0, bin = 1'b0;
  logic         in_valid = 1'b0, serial_en = 1'b0, serial_start = 1'b0;
  logic         dif, bor, dif_q, bor_q, out_valid;
  logic [W-1:0] serial_result;
  logic         serial_borrow, serial_done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] last_res = '0;
  logic         last_brw = 1'b0;

  full_subtractor #(.SERIAL_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .bin(bin),
    .dif(dif), .bor(bor), .in_valid(in_valid), .serial_en(serial_en),
    .serial_start(serial_start), .dif_q(dif_q), .bor_q(bor_q),
    .out_valid(out_valid), .serial_result(serial_result),
    .serial_borrow(serial_borrow), .serial_done(serial_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // {borrow, difference} of x - y - z as plain integer arithmetic
  function automatic logic [1:0] cell_ref(input int x, input int y, input int z);
    int t;
    t = x - y - z;
    return {logic'(t < 0), logic'((t % 2) != 0)};
  endfunction

  function automatic logic [W:0] sub_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic z);
    longint t;
    t = longint'(x) - longint'(y) - longint'(z);
    return {logic'(t < 0), W'(t)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input logic ea, input logic eb, input logic ebin);
    logic [1:0] e;
    e = cell_ref(int'(ea), int'(eb), int'(ebin));
    chk("out_valid", out_valid, 1);
    chk("dif_q", dif_q, e[0]);
    chk("bor_q", bor_q, e[1]);
  endtask

  // Idle/stall cycle: either no valid, or valid without serial_en. serial_start is randomised to show it is ignored.
  task automatic stall_cycle();
    logic ea, eb, ebin, kind;
    kind = 1'($urandom_range(0, 1));
    ea = 1'($urandom_range(0, 1));
    eb = 1'($urandom_range(0, 1));
    ebin = 1'($urandom_range(0, 1));
    a = ea; b = eb; bin = ebin;
    in_valid = kind; serial_en = ~kind; serial_start = 1'($urandom_range(0, 1));
    tick();
    chk("stall_done", serial_done, 0);
    chk("stall_res_hold", serial_result, last_res);
    if (kind) chk_reg(ea, eb, ebin);
    else chk("stall_out_valid", out_valid, 0);
  endtask

  task automatic send_op(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         input bit use_start, input int stall_pct, input int nbits);
    logic [W:0] e;
    logic       ebin;
    e = sub_ref(ma, mb, use_start ? mbin : 1'b0);
    for (int i = 0; i < nbits; i++) begin
      while ($urandom_range(0, 99) < stall_pct) stall_cycle();
      ebin = (use_start && i == 0) ? mbin : 1'($urandom_range(0, 1));
      a = ma[i]; b = mb[i]; bin = ebin;
      in_valid = 1'b1; serial_en = 1'b1; serial_start = (use_start && i == 0);
      #1;
      chk("comb_dif", dif, cell_ref(int'(ma[i]), int'(mb[i]), int'(ebin)) & 2'b01);
      tick();
      chk_reg(ma[i], mb[i], ebin);
      if (i == W - 1) begin
        chk("done", serial_done, 1);
        chk("result", serial_result, e[W-1:0]);
        chk("borrow", serial_borrow, e[W]);
        last_res = e[W-1:0];
        last_brw = e[W];
      end else begin
        chk("done_early", serial_done, 0);
        chk("res_hold", serial_result, last_res);
      end
    end
    in_valid = 1'b0; serial_en = 1'b0; serial_start = 1'b0;
    tick();
    chk("done_pulse_end", serial_done, 0);
    chk("brw_hold", serial_borrow, last_brw);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dif_q"}, dif_q, 0);
    chk({tag, "_bor_q"}, bor_q, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_result"}, serial_result, 0);
    chk({tag, "_borrow"}, serial_borrow, 0);
    chk({tag, "_done"}, serial_done, 0);
  endtask

  initial begin
    logic [1:0] e;
    logic [W-1:0] ra, rb;
    #3;
    chk_all_zero("reset");

    // Exhaustive combinational sweep, also while in reset
    for (int k = 0; k < 8; k++) begin
      a = 1'(k >> 2); b = 1'(k >> 1); bin = 1'(k);
      #10;
      e = cell_ref((k >> 2) & 1, (k >> 1) & 1, k & 1);
      chk("sweep_dif", dif, e[0]);
      chk("sweep_bor", bor, e[1]);
    end
    a = 1'b1; b = 1'b1; bin = 1'b0;
    #10;
    chk("rep110_dif", dif, 0);
    chk("rep110_bor", bor, 0);
    #10;
    chk("rep110_dif_stable", dif, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Registered latency: one-cycle valid pulse
    a = 1'b0; b = 1'b1; bin = 1'b0; in_valid = 1'b1;
    tick();
    chk("lat_dif_q", dif_q, 1);
    chk("lat_bor_q", bor_q, 1);
    chk("lat_out_valid", out_valid, 1);
    in_valid = 1'b0; a = 1'b1; b = 1'b0;
    tick();
    chk("lat_out_valid_drop", out_valid, 0);
    chk("lat_dif_q_hold", dif_q, 1);
    chk("lat_bor_q_hold", bor_q, 1);

    // Directed serial operations
    send_op(8'h05, 8'h03, 1'b0, 1, 0, W);
    send_op(8'h03, 8'h05, 1'b0, 1, 0, W);
    send_op(8'h00, 8'h00, 1'b1, 1, 0, W);
    send_op(8'h05, 8'h03, 1'b0, 1, 40, W);

    // Abort at bit 4, then restart
    send_op(8'hA7, 8'h1C, 1'b1, 1, 0, 4);
    send_op(8'h3C, 8'h5A, 1'b0, 1, 20, W);

    // Reset mid-operation clears everything at once
    send_op(8'h77, 8'h11, 1'b0, 1, 0, 3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    last_res = '0; last_brw = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    chk_all_zero("after_mid_reset");

    // No serial_start after reset: cnt=0, brw=0 act as bit 0
    send_op(8'h10, 8'h21, 1'b1, 0, 0, W);

    // Random operations with random stalls and occasional aborts
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0)
        send_op(W'($urandom), W'($urandom), 1'($urandom), 1, 20, $urandom_range(1, W - 1));
      send_op(ra, rb, 1'($urandom_range(0, 1)), 1, 25, W);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
